// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage feeding decode.
// Owns the program counter and keeps at most one instruction-memory request
// in flight. Fetched words go to decode over a valid/ready handshake.
// Execute-stage redirects flush buffered instructions and squash any fetch
// that is still in flight.
// Build option: define FETCH_SKID_BUF_EN to add a one-entry skid buffer so
// fetching continues for one more word while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {S_RESET, S_REQ, S_HOLD} state_t;

  state_t      state, state_n;
  logic        kill, kill_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] addr_n;
  logic        valid_n;
  logic [31:0] instr_n, pc_n;
  logic        drain, accept, room;
  logic [31:0] target;

`ifdef FETCH_SKID_BUF_EN
  logic        skid_valid, skid_valid_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc, skid_pc_n;
`endif

  // Next-state, next-PC and output/skid register contents for this edge.
  always_comb begin
    state_n   = state;
    kill_n    = kill;
    pend_pc_n = pend_pc;
    addr_n    = imem_address;
    valid_n   = out_valid;
    instr_n   = out_instr;
    pc_n      = out_pc;
`ifdef FETCH_SKID_BUF_EN
    skid_valid_n = skid_valid;
    skid_instr_n = skid_instr;
    skid_pc_n    = skid_pc;
`endif
    target = redirect_pc & 32'hFFFF_FFFC;
    drain  = out_valid && out_ready;
    accept = 1'b0;
    room   = 1'b0;

    // A transfer empties the output register; a buffered entry refills it.
    if (drain) begin
`ifdef FETCH_SKID_BUF_EN
      if (skid_valid) begin
        valid_n      = 1'b1;
        instr_n      = skid_instr;
        pc_n         = skid_pc;
        skid_valid_n = 1'b0;
      end else begin
        valid_n = 1'b0;
      end
`else
      valid_n = 1'b0;
`endif
    end

`ifdef FETCH_SKID_BUF_EN
    room = !skid_valid_n;
`else
    room = !valid_n;
`endif

    case (state)
      S_RESET: begin
        state_n = S_REQ;
        if (redirect_i) addr_n = target;
      end
      S_REQ: begin
        if (imem_resp) begin
          kill_n = 1'b0;
          if (redirect_i) begin
            addr_n = target;
          end else if (kill) begin
            addr_n = pend_pc;
          end else begin
            accept = 1'b1;
            addr_n = imem_address + 32'd4;
          end
        end else if (redirect_i) begin
          kill_n    = 1'b1;
          pend_pc_n = target;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          addr_n  = target;
          state_n = S_REQ;
        end else if (room) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_RESET;
    endcase

    if (accept) begin
      if (!valid_n) begin
        valid_n = 1'b1;
        instr_n = imem_rdata;
        pc_n    = imem_address;
      end
`ifdef FETCH_SKID_BUF_EN
      else begin
        skid_valid_n = 1'b1;
        skid_instr_n = imem_rdata;
        skid_pc_n    = imem_address;
      end
      state_n = skid_valid_n ? S_HOLD : S_REQ;
`else
      state_n = S_HOLD;
`endif
    end

    if (redirect_i) begin
      valid_n = 1'b0;
`ifdef FETCH_SKID_BUF_EN
      skid_valid_n = 1'b0;
`endif
    end
  end

  // State, memory request and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RESET;
      imem_read    <= 1'b0;
      imem_address <= RESET_PC;
      kill         <= 1'b0;
      pend_pc      <= '0;
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_pc       <= '0;
    end else begin
      state        <= state_n;
      imem_read    <= (state_n == S_REQ);
      imem_address <= addr_n;
      kill         <= kill_n;
      pend_pc      <= pend_pc_n;
      out_valid    <= valid_n;
      out_instr    <= instr_n;
      out_pc       <= pc_n;
    end
  end

`ifdef FETCH_SKID_BUF_EN
  // Skid buffer holding the word fetched while decode was stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      skid_valid <= skid_valid_n;
      skid_instr <= skid_instr_n;
      skid_pc    <= skid_pc_n;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A behavioural memory
// answers requests after a programmable latency; expected decode transfers
// are queued by the stimulus and popped by an independent monitor.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk, rst;
  logic        imem_read, imem_resp;
  logic [31:0] imem_address, imem_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  int          check_count = 0;
  int          pass_count  = 0;
  int          lat = 1;
  bit          busy = 0;
  int          cnt = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] last_req = '0;
  logic [31:0] req_log[$];
  exp_t        exp_q[$];
  exp_t        mon_e;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .redirect_i(redirect_i), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a simple address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a - 32'h4000_0060) << 10) | 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Memory model: one request at a time, response after lat cycles.
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        busy = 0;
        imem_resp = 1'b0;
      end else begin
        if (imem_resp) begin
          imem_resp = 1'b0;
          busy = 0;
        end
        if (busy) begin
          checkOutput("imem_read_held", {31'd0, imem_read}, 32'd1);
          checkOutput("imem_address_held", imem_address, req_addr);
          if (cnt == 1) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(req_addr);
          end
          cnt--;
        end else if (imem_read) begin
          busy     = 1;
          cnt      = lat;
          req_addr = imem_address;
          last_req = imem_address;
          req_log.push_back(imem_address);
        end
      end
    end
  end

  // Monitor: every decode transfer must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_transfer: got pc %h, expected no transfer", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("out_pc", out_pc, mon_e.pc);
        checkOutput("out_instr", out_instr, mon_e.instr);
      end
    end
  end

  task automatic wait_drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin done = 1; break; end
      @(posedge clk); #2;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin done = 1; break; end
      @(posedge clk); #2;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_resp_at(input string name, input logic [31:0] addr);
    bit done;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_resp && imem_address == addr) begin done = 1; break; end
      @(posedge clk); #2;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_outstanding(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_read && !imem_resp) begin done = 1; break; end
      @(posedge clk); #2;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr);
    bit done;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_log.size() > 0) begin done = 1; break; end
      @(posedge clk); #2;
    end
    if (done) checkOutput(name, req_log[0], addr);
    else checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect_i  = 1'b1;
    @(posedge clk); #2;
    redirect_i  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_imem_read"}, {31'd0, imem_read}, 32'd0);
    checkOutput({tag, "_imem_address"}, imem_address, RESET_PC);
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_out_instr"}, out_instr, 32'd0);
    checkOutput({tag, "_out_pc"}, out_pc, 32'd0);
  endtask

  task automatic applyStimulus();
    // Reset, first fetch and a four-instruction sequential stream.
    rst = 1'b1; out_ready = 1'b0; redirect_i = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values("reset");
    push_exp(32'h4000_0060, 32'h0000_0013);
    push_exp(32'h4000_0064, 32'h0000_1013);
    push_exp(32'h4000_0068, 32'h0000_2013);
    push_exp(32'h4000_006C, 32'h0000_3013);
    out_ready = 1'b1;
    rst = 1'b0;
    @(posedge clk); #2;
    checkOutput("first_imem_read", {31'd0, imem_read}, 32'd1);
    checkOutput("first_imem_address", imem_address, 32'h4000_0060);
    wait_drain("stream_drain");
    out_ready = 1'b0;

    // Decode stall for five cycles.
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      checkOutput("stall_valid_held", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_pc_held", out_pc, 32'h4000_0070);
      checkOutput("stall_instr_held", out_instr, 32'h0000_4013);
    end
    checkOutput("stall_read_idle", {31'd0, imem_read}, 32'd0);
`ifdef FETCH_SKID_BUF_EN
    checkOutput("stall_last_request", last_req, 32'h4000_0074);
`else
    checkOutput("stall_last_request", last_req, 32'h4000_0070);
`endif
    push_exp(32'h4000_0070, 32'h0000_4013);
    push_exp(32'h4000_0074, 32'h0000_5013);
    out_ready = 1'b1;
    wait_drain("stall_release_drain");
    out_ready = 1'b0;

    // Redirect in the same cycle as a memory response.
    do_redirect(32'h4000_1002);
    wait_resp_at("resp_at_first_target", 32'h4000_1000);
    req_log.delete();
    do_redirect(32'h4000_2000);
    checkOutput("valid_after_resp_redirect", {31'd0, out_valid}, 32'd0);
    wait_req("request_after_resp_redirect", 32'h4000_2000);
    push_exp(32'h4000_2000, mem_word(32'h4000_2000));
    push_exp(32'h4000_2004, mem_word(32'h4000_2004));
    out_ready = 1'b1;
    wait_drain("resp_redirect_drain");
    out_ready = 1'b0;

    // Redirect in the same cycle as a decode transfer.
    wait_valid("xfer_valid");
    push_exp(32'h4000_2008, mem_word(32'h4000_2008));
    req_log.delete();
    out_ready = 1'b1;
    do_redirect(32'h4000_3000);
    out_ready = 1'b0;
    checkOutput("valid_after_xfer_redirect", {31'd0, out_valid}, 32'd0);
    wait_req("request_after_xfer_redirect", 32'h4000_3000);
    push_exp(32'h4000_3000, mem_word(32'h4000_3000));
    push_exp(32'h4000_3004, mem_word(32'h4000_3004));
    out_ready = 1'b1;
    wait_drain("xfer_redirect_drain");
    out_ready = 1'b0;

    // Reset asserted while a request is outstanding.
    wait_outstanding("outstanding_before_reset");
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    lat = 3;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    checkOutput("restart_imem_read", {31'd0, imem_read}, 32'd1);
    checkOutput("restart_imem_address", imem_address, RESET_PC);

    // Redirect while that request is still in flight.
    req_log.delete();
    out_ready = 1'b1;
    do_redirect(32'h4000_0203);
    wait_req("request_after_kill", 32'h4000_0200);
    push_exp(32'h4000_0200, 32'h0006_8013);
    push_exp(32'h4000_0204, 32'h0006_9013);
    wait_drain("kill_drain");
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Main sequence and summary.
  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Safety net in case the sequence itself stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
